fpu_scheduler: RTL and testbench
================================

# fpu_scheduler

Controller that shares one FPU core between two requesters. It arbitrates pending requests round-robin, latches the winner's operands and starts the core. It then waits for completion and returns the result and status to the granted requester. It sits between the two client blocks and the single FPU core instance, all in the clock_100Khz domain.

## Interface
- TIMEOUT_CYCLES, 1000: watchdog limit in WAIT, in clock cycles; used only with FPU_SCHED_TIMEOUT_EN.
- clock_100Khz  in  1  system clock.
- reset  in  1  reset, asynchronous, active-low.
- req_i  in  2  per-requester request level. Held high with stable operands until that requester's rsp_valid_o pulse.
- op_a_i  in  2x32  packed operand A per requester; [0] = requester 0.
- op_b_i  in  2x32  packed operand B per requester.
- rsp_valid_o  in/out: output  2  one-hot, one-cycle response pulse to the granted requester.
- rsp_data_o  out  32  result; valid while rsp_valid_o is non-zero.
- rsp_status_o  out  1  core status bit for the response.
- rsp_timeout_o  out  1  response produced by watchdog, not by the core.
- busy_o  out  1  high in every state except IDLE.
- fpu_start_o  out  1  one-cycle start pulse to the core.
- fpu_op_a_o, fpu_op_b_o  out  32 each  latched operands; stable from ISSUE until return to IDLE.
- fpu_abort_o  out  1  one-cycle abort pulse on timeout.
- fpu_done_i  in  1  core completion pulse.
- fpu_data_i  in  32  core result; sampled when fpu_done_i=1.
- fpu_status_i  in  1  core status; sampled when fpu_done_i=1.

## Operation
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE: if any req_i bit is high, select a winner, latch its operands and its index into grant, and go to ISSUE.
- Arbitration: a single request wins directly. With both requests high, the index opposite last_grant wins, and last_grant is updated to that winner.
- ISSUE: fpu_start_o=1 for exactly this cycle, then go to WAIT.
- WAIT: when fpu_done_i=1, latch fpu_data_i and fpu_status_i, clear rsp_timeout, and go to RESPOND.
- RESPOND: rsp_valid_o[grant]=1 for one cycle, then go to IDLE.
- Requester handshake: req_i is sampled only in IDLE. A requester whose req is still high on the cycle after its rsp_valid pulse is treated as a new request.
- fpu_done_i outside WAIT is ignored.
- Operands pass through unmodified. The 32-bit format is 1 sign / 10 exponent / 21 fraction, bias 511; the block does no arithmetic on fields.
- Reset values: state=IDLE, last_grant=1 (requester 0 wins the first contention). All outputs are 0, including rsp_data_o, the fpu_op buses and busy_o.
- Reset mid-operation clears all state immediately. No response is issued for the interrupted request; the core shares the same reset.

## Timing
- The req_i rising edge seen in IDLE at edge k gives ISSUE at k+1 (start pulse visible), then WAIT from k+2.
- When the core raises done D cycles after the start pulse, RESPOND follows on the next cycle. Request-to-rsp_valid latency is therefore D+2 cycles.
- Back-to-back operation: IDLE can grant on the cycle after RESPOND. The minimum issue interval is 4 cycles with D=1.
- rsp_data_o, rsp_status_o and rsp_timeout_o hold their last value until the next RESPOND.

## Configuration
- FPU_SCHED_TIMEOUT_EN defined:
  - A WAIT cycle counter is cleared on entry to WAIT.
  - When the counter reaches TIMEOUT_CYCLES-1 without done, fpu_abort_o=1 for one cycle.
  - The result is forced to quiet NaN 32'h7FF00000, with rsp_status_o=1 and rsp_timeout_o=1, and the block goes to RESPOND.
  - If fpu_done_i arrives on the expiry cycle, done wins and no abort is issued.
- FPU_SCHED_TIMEOUT_EN undefined: WAIT waits indefinitely, no counter is built, and fpu_abort_o and rsp_timeout_o are tied to 0.

## Structure
- The shared package fpu_pkg holds:
  - the state enum;
  - EXP_W=10, FRAC_W=21, BIAS=511;
  - the QNAN constant 32'h7FF00000.
- One sub-module, rr_arbiter2: inputs req[1:0] and last_grant; outputs grant index and valid. It is purely combinational, and the scheduler holds the last_grant register.

## Test plan
- Single request: only req_i[0] high with op_a=32'h3FF00000; core done with D=3 and data 32'h40000000 -> start pulse once, rsp_valid_o=2'b01 five cycles after the request, rsp_data_o=32'h40000000.
- Contention: both requests high from reset -> grants in the order 0, 1, 0, 1 across four transactions, and each requester gets exactly one rsp_valid per grant.
- Stray done: fpu_done_i pulsed while in IDLE or ISSUE -> no state change and no response.
- Timeout (macro on, TIMEOUT_CYCLES=8): core never completes -> fpu_abort_o pulse, then rsp_data_o=32'h7FF00000 with rsp_status_o=1 and rsp_timeout_o=1. Repeat with done arriving on the expiry cycle -> core data is returned and no abort is issued.
- Reset in WAIT: reset asserted low mid-WAIT -> all outputs are 0 immediately, no rsp_valid pulse, and the next request is served from IDLE with requester 0 priority.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU scheduler.
// Float format: 1 sign / 10 exponent / 21 fraction, bias 511.
package fpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } sched_state_e;

    localparam int EXP_W  = 10;
    localparam int FRAC_W = 21;
    localparam int BIAS   = 511;
    localparam int WORD_W = 1 + EXP_W + FRAC_W;

    localparam logic [WORD_W-1:0] QNAN = 32'h7FF0_0000;

    function automatic logic [1:0] grant_onehot(input logic idx);
        logic [1:0] vec;
        if (idx) begin
            vec = 2'b10;
        end else begin
            vec = 2'b01;
        end
        return vec;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; the caller owns the last_grant register.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    // Single request wins outright; on contention the side opposite last_grant wins
    always_comb begin
        valid = |req;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/fpu_scheduler.sv
// Shares one FPU core between two requesters: round-robin grant, issue, wait, respond.
// Optional WAIT watchdog is compiled in with FPU_SCHED_TIMEOUT_EN.
module fpu_scheduler
    import fpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                   clock_100Khz,
    input  logic                   reset,
    input  logic [1:0]             req_i,
    input  logic [1:0][WORD_W-1:0] op_a_i,
    input  logic [1:0][WORD_W-1:0] op_b_i,
    output logic [1:0]             rsp_valid_o,
    output logic [WORD_W-1:0]      rsp_data_o,
    output logic                   rsp_status_o,
    output logic                   rsp_timeout_o,
    output logic                   busy_o,
    output logic                   fpu_start_o,
    output logic [WORD_W-1:0]      fpu_op_a_o,
    output logic [WORD_W-1:0]      fpu_op_b_o,
    output logic                   fpu_abort_o,
    input  logic                   fpu_done_i,
    input  logic [WORD_W-1:0]      fpu_data_i,
    input  logic                   fpu_status_i
);

    sched_state_e      state_r, next_state_s;
    logic              last_grant_r;
    logic              grant_r;
    logic [WORD_W-1:0] op_a_r, op_b_r;
    logic [WORD_W-1:0] rsp_data_r;
    logic              rsp_status_r, rsp_timeout_r;
    logic [1:0]        rsp_valid_r;
    logic              busy_r, start_r, abort_r;

    logic              arb_grant_s, arb_valid_s;
    logic              load_s, capture_s, expire_s;
    logic              wd_expire_s;

    rr_arbiter2 u_arb (
        .req        (req_i),
        .last_grant (last_grant_r),
        .grant      (arb_grant_s),
        .valid      (arb_valid_s)
    );

`ifdef FPU_SCHED_TIMEOUT_EN
    localparam int              WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_r;

    // Counts WAIT cycles; held at zero outside WAIT so every entry starts fresh
    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else if (state_r != ST_WAIT) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end
    end

    assign wd_expire_s = (state_r == ST_WAIT) && (wd_cnt_r == WD_LAST);
`else
    assign wd_expire_s = 1'b0;
`endif

    // Next-state decode; a done on the expiry cycle takes priority over the watchdog
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        capture_s    = 1'b0;
        expire_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arb_valid_s) begin
                    next_state_s = ST_ISSUE;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                next_state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (fpu_done_i) begin
                    next_state_s = ST_RESPOND;
                    capture_s    = 1'b1;
                end else if (wd_expire_s) begin
                    next_state_s = ST_RESPOND;
                    expire_s     = 1'b1;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESPOND: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register and next-state-decoded control outputs
    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            start_r     <= 1'b0;
            abort_r     <= 1'b0;
            rsp_valid_r <= 2'b00;
        end else begin
            state_r     <= next_state_s;
            busy_r      <= (next_state_s != ST_IDLE);
            start_r     <= (next_state_s == ST_ISSUE);
            abort_r     <= expire_s;
            rsp_valid_r <= (next_state_s == ST_RESPOND) ? grant_onehot(grant_r) : 2'b00;
        end
    end

    // Grant bookkeeping and operand latch; last_grant only moves on contention
    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            last_grant_r <= 1'b1;
            grant_r      <= 1'b0;
            op_a_r       <= {WORD_W{1'b0}};
            op_b_r       <= {WORD_W{1'b0}};
        end else if (load_s) begin
            grant_r <= arb_grant_s;
            op_a_r  <= op_a_i[arb_grant_s];
            op_b_r  <= op_b_i[arb_grant_s];
            if (req_i == 2'b11) begin
                last_grant_r <= arb_grant_s;
            end
        end
    end

    // Response payload, held until the next completion or watchdog expiry
    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            rsp_data_r    <= {WORD_W{1'b0}};
            rsp_status_r  <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else if (capture_s) begin
            rsp_data_r    <= fpu_data_i;
            rsp_status_r  <= fpu_status_i;
            rsp_timeout_r <= 1'b0;
        end else if (expire_s) begin
            rsp_data_r    <= QNAN;
            rsp_status_r  <= 1'b1;
            rsp_timeout_r <= 1'b1;
        end
    end

    assign rsp_valid_o   = rsp_valid_r;
    assign rsp_data_o    = rsp_data_r;
    assign rsp_status_o  = rsp_status_r;
    assign rsp_timeout_o = rsp_timeout_r;
    assign busy_o        = busy_r;
    assign fpu_start_o   = start_r;
    assign fpu_op_a_o    = op_a_r;
    assign fpu_op_b_o    = op_b_r;
    assign fpu_abort_o   = abort_r;

endmodule

// File: tb/tb_fpu_scheduler.sv
// Directed, scoreboard-based bench for fpu_scheduler; the FPU core is driven from the stimulus.
// Watchdog cases run only when FPU_SCHED_TIMEOUT_EN is defined (TIMEOUT_CYCLES=8).
module tb_fpu_scheduler;

    localparam int TO_CYC = 8;

    logic              clock_100Khz = 1'b0;
    logic              reset;
    logic [1:0]        req_i;
    logic [1:0][31:0]  op_a_i, op_b_i;
    logic [1:0]        rsp_valid_o;
    logic [31:0]       rsp_data_o;
    logic              rsp_status_o, rsp_timeout_o, busy_o, fpu_start_o, fpu_abort_o;
    logic [31:0]       fpu_op_a_o, fpu_op_b_o;
    logic              fpu_done_i;
    logic [31:0]       fpu_data_i;
    logic              fpu_status_i;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] data;
        logic        status;
        logic        tmo;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   failed    = 0;
    int   cyc       = 0;
    int   rsp_cnt   = 0;
    int   abort_cnt = 0;
    int   n_exp     = 0;

    fpu_scheduler #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clock_100Khz (clock_100Khz),
        .reset        (reset),
        .req_i        (req_i),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_status_o (rsp_status_o),
        .rsp_timeout_o(rsp_timeout_o),
        .busy_o       (busy_o),
        .fpu_start_o  (fpu_start_o),
        .fpu_op_a_o   (fpu_op_a_o),
        .fpu_op_b_o   (fpu_op_b_o),
        .fpu_abort_o  (fpu_abort_o),
        .fpu_done_i   (fpu_done_i),
        .fpu_data_i   (fpu_data_i),
        .fpu_status_i (fpu_status_i)
    );

    always #5000 clock_100Khz = ~clock_100Khz;

    // Cycle counter and pulse monitors (count the value held during the previous cycle)
    always @(posedge clock_100Khz) begin
        cyc <= cyc + 1;
        if (rsp_valid_o !== 2'b00) rsp_cnt <= rsp_cnt + 1;
        if (fpu_abort_o === 1'b1) abort_cnt <= abort_cnt + 1;
    end

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
        $fatal(1, "bench watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic pick(input logic [1:0] r, input logic last);
        if (r == 2'b11) return ~last;
        return r[1];
    endfunction

    function automatic logic [1:0] onehot(input logic g);
        return g ? 2'b10 : 2'b01;
    endfunction

    task automatic wait_start(input logic g, output int t_start);
        int n;
        n = 0;
        do begin
            @(negedge clock_100Khz);
            n++;
        end while (fpu_start_o !== 1'b1 && n < 20);
        check("start_seen", fpu_start_o, 1'b1);
        t_start = cyc;
        check("op_a_latched", fpu_op_a_o, op_a_i[g]);
        check("op_b_latched", fpu_op_b_o, op_b_i[g]);
    endtask

    task automatic wait_rsp(input logic [1:0] drop, output int t_rsp);
        int   n;
        exp_t e;
        n = 0;
        while (rsp_valid_o === 2'b00 && n < 40) begin
            @(negedge clock_100Khz);
            n++;
        end
        t_rsp = cyc;
        check("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("rsp_valid", rsp_valid_o, e.valid);
            check("rsp_data", rsp_data_o, e.data);
            check("rsp_status", rsp_status_o, e.status);
            check("rsp_timeout", rsp_timeout_o, e.tmo);
            req_i = req_i & ~drop;
            @(negedge clock_100Khz);
            check("rsp_one_cycle", rsp_valid_o, 2'b00);
            check("rsp_data_hold", rsp_data_o, e.data);
        end
    endtask

    task automatic do_txn(input int d, input logic g, input logic [31:0] cdata, input logic cstat,
                          input logic [1:0] drop, output int t_start, output int t_rsp);
        int a0;
        wait_start(g, t_start);
        a0 = abort_cnt;
        for (int i = 0; i < d; i++) begin
            @(negedge clock_100Khz);
            check("start_pulse_once", fpu_start_o, 1'b0);
            check("no_early_rsp", rsp_valid_o, 2'b00);
        end
        fpu_done_i   = 1'b1;
        fpu_data_i   = cdata;
        fpu_status_i = cstat;
        sb_q.push_back('{onehot(g), cdata, cstat, 1'b0});
        n_exp++;
        @(negedge clock_100Khz);
        fpu_done_i   = 1'b0;
        fpu_data_i   = 32'hDEAD_BEEF;
        fpu_status_i = ~cstat;
        wait_rsp(drop, t_rsp);
        check("no_abort", abort_cnt - a0, 0);
    endtask

    initial begin
        int   ts, tr, prev_ts, c0, r0;
        logic exp_last, g;

        reset        = 1'b0;
        req_i        = 2'b11;
        op_a_i[0]    = 32'h3FF0_0000;
        op_b_i[0]    = 32'h4010_0000;
        op_a_i[1]    = 32'hBFF0_0000;
        op_b_i[1]    = 32'h4020_0000;
        fpu_done_i   = 1'b0;
        fpu_data_i   = 32'h0000_0000;
        fpu_status_i = 1'b0;
        prev_ts      = 0;

        // Reset state
        @(negedge clock_100Khz);
        check("rst_busy", busy_o, 1'b0);
        check("rst_start", fpu_start_o, 1'b0);
        check("rst_rsp_valid", rsp_valid_o, 2'b00);
        check("rst_rsp_data", rsp_data_o, 32'h0);
        check("rst_rsp_status", rsp_status_o, 1'b0);
        check("rst_rsp_timeout", rsp_timeout_o, 1'b0);
        check("rst_op_a", fpu_op_a_o, 32'h0);
        check("rst_op_b", fpu_op_b_o, 32'h0);
        check("rst_abort", fpu_abort_o, 1'b0);
        @(negedge clock_100Khz);
        reset = 1'b1;

        // Contention from reset: round-robin order, back-to-back with D=1
        exp_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            g = pick(2'b11, exp_last);
            exp_last = g;
            do_txn(1, g, 32'h4000_0000 + 32'(i), logic'(i[0]), (i == 3) ? 2'b11 : 2'b00, ts, tr);
            check("cont_latency", tr - ts, 2);
            if (i > 0) check("issue_interval", ts - prev_ts, 4);
            prev_ts = ts;
        end

        // Single request, D=3: response five cycles after the request
        @(negedge clock_100Khz);
        req_i = 2'b01;
        c0 = cyc;
        do_txn(3, 1'b0, 32'h4000_0000, 1'b0, 2'b01, ts, tr);
        check("single_req_latency", tr - c0, 5);

        // Stray done while IDLE
        r0 = rsp_cnt;
        fpu_done_i = 1'b1;
        fpu_data_i = 32'hBAD0_0000;
        repeat (2) begin
            @(negedge clock_100Khz);
            check("idle_done_busy", busy_o, 1'b0);
            check("idle_done_rsp", rsp_valid_o, 2'b00);
        end
        fpu_done_i = 1'b0;
        @(negedge clock_100Khz);
        check("idle_done_data", rsp_data_o, 32'h4000_0000);
        check("idle_done_rsp_cnt", rsp_cnt - r0, 0);

        // Stray done during ISSUE, real done two cycles after start
        req_i = 2'b10;
        wait_start(1'b1, ts);
        fpu_done_i = 1'b1;
        fpu_data_i = 32'hBAD0_0001;
        @(negedge clock_100Khz);
        fpu_done_i = 1'b0;
        check("issue_done_busy", busy_o, 1'b1);
        check("issue_done_rsp", rsp_valid_o, 2'b00);
        @(negedge clock_100Khz);
        check("issue_done_wait", rsp_valid_o, 2'b00);
        fpu_done_i   = 1'b1;
        fpu_data_i   = 32'h4080_0000;
        fpu_status_i = 1'b1;
        sb_q.push_back('{2'b10, 32'h4080_0000, 1'b1, 1'b0});
        n_exp++;
        @(negedge clock_100Khz);
        fpu_done_i = 1'b0;
        wait_rsp(2'b10, tr);
        check("issue_done_latency", tr - ts, 3);

        // Done on the watchdog expiry cycle: core data wins, no abort
        req_i = 2'b10;
        do_txn(TO_CYC, 1'b1, 32'h4110_0000, 1'b0, 2'b10, ts, tr);
        check("expiry_done_latency", tr - ts, TO_CYC + 1);

`ifdef FPU_SCHED_TIMEOUT_EN
        // Core never completes: abort pulse, quiet NaN with status and timeout set
        begin
            int a0;
            req_i = 2'b01;
            wait_start(1'b0, ts);
            a0 = abort_cnt;
            sb_q.push_back('{2'b01, 32'h7FF0_0000, 1'b1, 1'b1});
            n_exp++;
            wait_rsp(2'b01, tr);
            check("timeout_latency", tr - ts, TO_CYC + 1);
            check("timeout_abort", abort_cnt - a0, 1);
        end
`endif

        // Reset in the middle of WAIT
        req_i = 2'b01;
        wait_start(1'b0, ts);
        repeat (2) @(negedge clock_100Khz);
        reset = 1'b0;
        req_i = 2'b00;
        #1;
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_rsp_valid", rsp_valid_o, 2'b00);
        check("midrst_rsp_data", rsp_data_o, 32'h0);
        check("midrst_rsp_status", rsp_status_o, 1'b0);
        check("midrst_op_a", fpu_op_a_o, 32'h0);
        check("midrst_op_b", fpu_op_b_o, 32'h0);
        r0 = rsp_cnt;
        repeat (2) @(negedge clock_100Khz);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock_100Khz);
            check("postrst_idle", busy_o, 1'b0);
        end
        check("postrst_no_rsp", rsp_cnt - r0, 0);

        // Requester 0 regains priority after reset
        exp_last = 1'b1;
        req_i = 2'b11;
        g = pick(2'b11, exp_last);
        do_txn(2, g, 32'h3F00_0001, 1'b1, 2'b11, ts, tr);
        check("postrst_latency", tr - ts, 3);

        repeat (2) @(negedge clock_100Khz);
        check("total_rsp", rsp_cnt, n_exp);
        check("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
